// File: rtl/jb_predict_unit.sv
// jb_predict_unit: jump/branch resolution with an integrated direct-mapped BTB.
//   Fetch port : i_f_pc -> o_f_pred_taken / o_f_pred_pc (combinational lookup)
//   EX port    : i_ex_* operands and control class -> o_pc_4, o_pc_imm,
//                o_redirect / o_redirect_pc (combinational resolve), table
//                training at the clock edge, o_mispredict_cnt (saturating).
//   clk / rst  : rising-edge clock, synchronous active-high reset.
module jb_predict_unit #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BTB_ENTRIES = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  i_f_pc,
  output logic             o_f_pred_taken,
  output logic [XLEN-1:0]  o_f_pred_pc,
  input  logic             i_ex_valid,
  input  logic [XLEN-1:0]  i_ex_pc,
  input  logic [XLEN-1:0]  i_rs1_data,
  input  logic [XLEN-1:0]  i_imm,
  input  logic             i_aluresult0,
  input  logic             i_jalr,
  input  logic             i_jal,
  input  logic             i_branch,
  input  logic             i_mret,
  input  logic             i_intr,
  input  logic [XLEN-1:0]  i_pc_mret,
  input  logic [XLEN-1:0]  i_pc_intr,
  input  logic             i_ex_pred_taken,
  input  logic [XLEN-1:0]  i_ex_pred_pc,
  output logic [XLEN-1:0]  o_pc_4,
  output logic [XLEN-1:0]  o_pc_imm,
  output logic             o_redirect,
  output logic [XLEN-1:0]  o_redirect_pc,
  output logic [CNT_W-1:0] o_mispredict_cnt
);

  localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  logic             valid_q [BTB_ENTRIES];
  logic [TAG_W-1:0] tag_q   [BTB_ENTRIES];
  logic [XLEN-1:0]  tgt_q   [BTB_ENTRIES];
  logic [1:0]       ctr_q   [BTB_ENTRIES];
  logic [CNT_W-1:0] cnt_q;

  // Fetch lookup
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;

  always_comb begin
    f_idx          = i_f_pc[IDX_W+1:2];
    f_tag          = i_f_pc[XLEN-1:IDX_W+2];
    f_hit          = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    o_f_pred_taken = f_hit && ctr_q[f_idx][1];
    o_f_pred_pc    = o_f_pred_taken ? tgt_q[f_idx] : i_f_pc + XLEN'(4);
  end

  // EX resolve
  logic             br_taken;
  logic             act_taken;
  logic [XLEN-1:0]  act_pc;
  logic             mispredict;

  always_comb begin
    o_pc_4   = i_ex_pc + XLEN'(4);
    o_pc_imm = i_ex_pc + i_imm;
    br_taken = i_branch && i_aluresult0;
    if (i_jalr)        act_pc = (i_rs1_data + i_imm) & ~XLEN'(1);
    else if (i_jal)    act_pc = o_pc_imm;
    else if (br_taken) act_pc = o_pc_imm;
    else if (i_intr)   act_pc = i_pc_intr;
    else if (i_mret)   act_pc = i_pc_mret;
    else               act_pc = o_pc_4;
    act_taken  = i_jalr || i_jal || br_taken || i_intr || i_mret;
    mispredict = i_ex_valid && ((act_taken != i_ex_pred_taken) ||
                                (act_taken && (act_pc != i_ex_pred_pc)));
    o_redirect       = mispredict;
    o_redirect_pc    = act_pc;
    o_mispredict_cnt = cnt_q;
  end

  // Training write decision
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  logic             wr_en;
  logic             wr_valid;
  logic [XLEN-1:0]  wr_tgt;
  logic [1:0]       wr_ctr;

  always_comb begin
    ex_idx   = i_ex_pc[IDX_W+1:2];
    ex_tag   = i_ex_pc[XLEN-1:IDX_W+2];
    ex_hit   = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    wr_en    = 1'b0;
    wr_valid = valid_q[ex_idx];
    wr_tgt   = tgt_q[ex_idx];
    wr_ctr   = ctr_q[ex_idx];
    if (i_ex_valid && !i_intr && !i_mret) begin
      if (i_jal || i_jalr) begin
        wr_en    = 1'b1;
        wr_valid = 1'b1;
        wr_tgt   = act_pc;
        wr_ctr   = 2'b11;
      end else if (i_branch) begin
        if (ex_hit) begin
          wr_en = 1'b1;
          if (br_taken) begin
            wr_tgt = o_pc_imm;
            wr_ctr = (ctr_q[ex_idx] == 2'b11) ? 2'b11 : ctr_q[ex_idx] + 2'b01;
          end else begin
            wr_ctr = (ctr_q[ex_idx] == 2'b00) ? 2'b00 : ctr_q[ex_idx] - 2'b01;
          end
        end else if (br_taken) begin
          wr_en    = 1'b1;
          wr_valid = 1'b1;
          wr_tgt   = o_pc_imm;
          wr_ctr   = 2'b10;
        end
      end else if (ex_hit) begin
        // A non-control instruction matching the entry means the entry aliases.
        wr_en    = 1'b1;
        wr_valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= 2'b01;
      end
      cnt_q <= '0;
    end else begin
      if (wr_en) begin
        valid_q[ex_idx] <= wr_valid;
        tag_q[ex_idx]   <= ex_tag;
        tgt_q[ex_idx]   <= wr_tgt;
        ctr_q[ex_idx]   <= wr_ctr;
      end
      if (mispredict && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_jb_predict_unit.sv
module tb_jb_predict_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_f_pc;
  logic        o_f_pred_taken;
  logic [31:0] o_f_pred_pc;
  logic        i_ex_valid;
  logic [31:0] i_ex_pc, i_rs1_data, i_imm;
  logic        i_aluresult0, i_jalr, i_jal, i_branch, i_mret, i_intr;
  logic [31:0] i_pc_mret, i_pc_intr;
  logic        i_ex_pred_taken;
  logic [31:0] i_ex_pred_pc;
  logic [31:0] o_pc_4, o_pc_imm;
  logic        o_redirect;
  logic [31:0] o_redirect_pc;
  logic [15:0] o_mispredict_cnt;
  logic        s_pred_taken, s_redirect;
  logic [31:0] s_pred_pc, s_pc_4, s_pc_imm, s_redirect_pc;
  logic [1:0]  s_cnt;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  jb_predict_unit #(.XLEN(32), .BTB_ENTRIES(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .i_f_pc(i_f_pc),
    .o_f_pred_taken(o_f_pred_taken), .o_f_pred_pc(o_f_pred_pc),
    .i_ex_valid(i_ex_valid), .i_ex_pc(i_ex_pc), .i_rs1_data(i_rs1_data),
    .i_imm(i_imm), .i_aluresult0(i_aluresult0), .i_jalr(i_jalr), .i_jal(i_jal),
    .i_branch(i_branch), .i_mret(i_mret), .i_intr(i_intr),
    .i_pc_mret(i_pc_mret), .i_pc_intr(i_pc_intr),
    .i_ex_pred_taken(i_ex_pred_taken), .i_ex_pred_pc(i_ex_pred_pc),
    .o_pc_4(o_pc_4), .o_pc_imm(o_pc_imm), .o_redirect(o_redirect),
    .o_redirect_pc(o_redirect_pc), .o_mispredict_cnt(o_mispredict_cnt)
  );

  // Same stimulus, narrow counter to exercise saturation.
  jb_predict_unit #(.XLEN(32), .BTB_ENTRIES(16), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .i_f_pc(i_f_pc),
    .o_f_pred_taken(s_pred_taken), .o_f_pred_pc(s_pred_pc),
    .i_ex_valid(i_ex_valid), .i_ex_pc(i_ex_pc), .i_rs1_data(i_rs1_data),
    .i_imm(i_imm), .i_aluresult0(i_aluresult0), .i_jalr(i_jalr), .i_jal(i_jal),
    .i_branch(i_branch), .i_mret(i_mret), .i_intr(i_intr),
    .i_pc_mret(i_pc_mret), .i_pc_intr(i_pc_intr),
    .i_ex_pred_taken(i_ex_pred_taken), .i_ex_pred_pc(i_ex_pred_pc),
    .o_pc_4(s_pc_4), .o_pc_imm(s_pc_imm), .o_redirect(s_redirect),
    .o_redirect_pc(s_redirect_pc), .o_mispredict_cnt(s_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    i_ex_valid = 0; i_ex_pc = '0; i_rs1_data = '0; i_imm = '0;
    i_aluresult0 = 0; i_jalr = 0; i_jal = 0; i_branch = 0; i_mret = 0; i_intr = 0;
    i_pc_mret = '0; i_pc_intr = '0; i_ex_pred_taken = 0; i_ex_pred_pc = '0;
  endtask

  task automatic test_reset();
    rst = 1; i_f_pc = 32'h100; clear_ex();
    step(); step();
    rst = 0;
    @(negedge clk);
    total++; if (o_f_pred_taken !== 1'b0) $display("FAIL reset_taken got=%0h exp=0", o_f_pred_taken); else passed++;
    total++; if (o_f_pred_pc !== 32'h104) $display("FAIL reset_pred_pc got=%0h exp=104", o_f_pred_pc); else passed++;
    total++; if (o_mispredict_cnt !== 16'd0) $display("FAIL reset_cnt got=%0d exp=0", o_mispredict_cnt); else passed++;
    total++; if (o_redirect !== 1'b0) $display("FAIL reset_redirect got=%0h exp=0", o_redirect); else passed++;
  endtask

  task automatic test_jal();
    step();
    i_ex_valid = 1; i_ex_pc = 32'h100; i_jal = 1; i_imm = 32'h40; i_f_pc = 32'h100;
    @(negedge clk);
    total++; if (o_redirect !== 1'b1) $display("FAIL jal_redirect got=%0h exp=1", o_redirect); else passed++;
    total++; if (o_redirect_pc !== 32'h140) $display("FAIL jal_redirect_pc got=%0h exp=140", o_redirect_pc); else passed++;
    total++; if (o_pc_4 !== 32'h104) $display("FAIL jal_pc_4 got=%0h exp=104", o_pc_4); else passed++;
    total++; if (o_pc_imm !== 32'h140) $display("FAIL jal_pc_imm got=%0h exp=140", o_pc_imm); else passed++;
    total++; if (o_f_pred_taken !== 1'b0) $display("FAIL jal_no_bypass got=%0h exp=0", o_f_pred_taken); else passed++;
    step(); clear_ex();
    @(negedge clk);
    total++; if (o_mispredict_cnt !== 16'd1) $display("FAIL jal_cnt got=%0d exp=1", o_mispredict_cnt); else passed++;
    total++; if (o_f_pred_taken !== 1'b1) $display("FAIL jal_trained_taken got=%0h exp=1", o_f_pred_taken); else passed++;
    total++; if (o_f_pred_pc !== 32'h140) $display("FAIL jal_trained_pc got=%0h exp=140", o_f_pred_pc); else passed++;
    i_f_pc = 32'h140;
    #1;
    total++; if (o_f_pred_taken !== 1'b0) $display("FAIL alias_miss got=%0h exp=0", o_f_pred_taken); else passed++;
    total++; if (o_f_pred_pc !== 32'h144) $display("FAIL alias_pred_pc got=%0h exp=144", o_f_pred_pc); else passed++;
  endtask

  task automatic test_alias_invalidate();
    step();
    i_ex_valid = 1; i_ex_pc = 32'h100; i_f_pc = 32'h100;
    @(negedge clk);
    total++; if (o_redirect !== 1'b0) $display("FAIL plain_redirect got=%0h exp=0", o_redirect); else passed++;
    step(); clear_ex();
    @(negedge clk);
    total++; if (o_f_pred_taken !== 1'b0) $display("FAIL invalidate_taken got=%0h exp=0", o_f_pred_taken); else passed++;
    total++; if (o_f_pred_pc !== 32'h104) $display("FAIL invalidate_pc got=%0h exp=104", o_f_pred_pc); else passed++;
  endtask

  task automatic test_branch();
    // outcome taken x3 then not-taken x2; expected prediction at EX and after update
    logic        tk  [5] = '{1, 1, 1, 0, 0};
    logic        pt  [5] = '{0, 1, 1, 1, 1};
    logic        rd  [5] = '{1, 0, 0, 1, 1};
    logic [31:0] rpc [5] = '{32'h1F8, 32'h1F8, 32'h1F8, 32'h204, 32'h204};
    logic        ft  [5] = '{1, 1, 1, 1, 0};
    logic [31:0] fpc [5] = '{32'h1F8, 32'h1F8, 32'h1F8, 32'h1F8, 32'h204};
    logic [15:0] cn  [5] = '{2, 2, 2, 3, 4};
    logic [1:0]  sc  [5] = '{2, 2, 2, 3, 3};
    for (int i = 0; i < 5; i++) begin
      step();
      i_ex_valid = 1; i_ex_pc = 32'h200; i_branch = 1; i_imm = 32'hFFFF_FFF8;
      i_aluresult0 = tk[i]; i_ex_pred_taken = pt[i]; i_ex_pred_pc = pt[i] ? 32'h1F8 : 32'h204;
      i_f_pc = 32'h200;
      @(negedge clk);
      total++; if (o_redirect !== rd[i]) $display("FAIL br%0d_redirect got=%0h exp=%0h", i, o_redirect, rd[i]); else passed++;
      total++; if (o_redirect_pc !== rpc[i]) $display("FAIL br%0d_redirect_pc got=%0h exp=%0h", i, o_redirect_pc, rpc[i]); else passed++;
      step(); clear_ex();
      @(negedge clk);
      total++; if (o_f_pred_taken !== ft[i]) $display("FAIL br%0d_pred_taken got=%0h exp=%0h", i, o_f_pred_taken, ft[i]); else passed++;
      total++; if (o_f_pred_pc !== fpc[i]) $display("FAIL br%0d_pred_pc got=%0h exp=%0h", i, o_f_pred_pc, fpc[i]); else passed++;
      total++; if (o_mispredict_cnt !== cn[i]) $display("FAIL br%0d_cnt got=%0d exp=%0d", i, o_mispredict_cnt, cn[i]); else passed++;
      total++; if (s_cnt !== sc[i]) $display("FAIL br%0d_sat_cnt got=%0d exp=%0d", i, s_cnt, sc[i]); else passed++;
    end
  endtask

  task automatic test_jalr();
    step();
    i_ex_valid = 1; i_ex_pc = 32'h300; i_jalr = 1; i_rs1_data = 32'h1001; i_imm = 32'h2;
    @(negedge clk);
    total++; if (o_redirect !== 1'b1) $display("FAIL jalr_redirect got=%0h exp=1", o_redirect); else passed++;
    total++; if (o_redirect_pc !== 32'h1002) $display("FAIL jalr_redirect_pc got=%0h exp=1002", o_redirect_pc); else passed++;
    step(); clear_ex(); i_f_pc = 32'h300;
    @(negedge clk);
    total++; if (o_mispredict_cnt !== 16'd5) $display("FAIL jalr_cnt got=%0d exp=5", o_mispredict_cnt); else passed++;
    total++; if (s_cnt !== 2'd3) $display("FAIL sat_cnt_5 got=%0d exp=3", s_cnt); else passed++;
    total++; if (o_f_pred_pc !== 32'h1002) $display("FAIL jalr_trained_pc got=%0h exp=1002", o_f_pred_pc); else passed++;
  endtask

  task automatic test_intr_mret();
    step();
    i_ex_valid = 1; i_ex_pc = 32'h300; i_intr = 1; i_pc_intr = 32'h80; i_f_pc = 32'h300;
    @(negedge clk);
    total++; if (o_redirect !== 1'b1) $display("FAIL intr_redirect got=%0h exp=1", o_redirect); else passed++;
    total++; if (o_redirect_pc !== 32'h80) $display("FAIL intr_redirect_pc got=%0h exp=80", o_redirect_pc); else passed++;
    step(); clear_ex();
    @(negedge clk);
    total++; if (o_f_pred_pc !== 32'h1002) $display("FAIL intr_btb_kept got=%0h exp=1002", o_f_pred_pc); else passed++;
    // jal and intr together: jal target, no training
    i_ex_valid = 1; i_ex_pc = 32'h400; i_jal = 1; i_intr = 1; i_imm = 32'h20; i_pc_intr = 32'h80;
    #1;
    total++; if (o_redirect_pc !== 32'h420) $display("FAIL jal_intr_pc got=%0h exp=420", o_redirect_pc); else passed++;
    step(); clear_ex(); i_f_pc = 32'h400;
    @(negedge clk);
    total++; if (o_f_pred_taken !== 1'b0) $display("FAIL jal_intr_no_train got=%0h exp=0", o_f_pred_taken); else passed++;
    total++; if (o_mispredict_cnt !== 16'd7) $display("FAIL intr_cnt got=%0d exp=7", o_mispredict_cnt); else passed++;
    // mret predicted correctly, then with wrong target
    i_ex_valid = 1; i_ex_pc = 32'h500; i_mret = 1; i_pc_mret = 32'h600;
    i_ex_pred_taken = 1; i_ex_pred_pc = 32'h600;
    #1;
    total++; if (o_redirect !== 1'b0) $display("FAIL mret_ok_redirect got=%0h exp=0", o_redirect); else passed++;
    i_ex_pred_pc = 32'h604;
    #1;
    total++; if (o_redirect !== 1'b1) $display("FAIL mret_bad_redirect got=%0h exp=1", o_redirect); else passed++;
    total++; if (o_redirect_pc !== 32'h600) $display("FAIL mret_pc got=%0h exp=600", o_redirect_pc); else passed++;
    step(); clear_ex();
    @(negedge clk);
    total++; if (o_mispredict_cnt !== 16'd8) $display("FAIL mret_cnt got=%0d exp=8", o_mispredict_cnt); else passed++;
  endtask

  task automatic test_ex_invalid_wrap();
    i_jal = 1; i_ex_pc = 32'h700; i_imm = 32'h10; i_f_pc = 32'h700;
    #1;
    total++; if (o_redirect !== 1'b0) $display("FAIL invalid_redirect got=%0h exp=0", o_redirect); else passed++;
    step(); clear_ex();
    @(negedge clk);
    total++; if (o_f_pred_taken !== 1'b0) $display("FAIL invalid_no_train got=%0h exp=0", o_f_pred_taken); else passed++;
    total++; if (o_mispredict_cnt !== 16'd8) $display("FAIL invalid_cnt_hold got=%0d exp=8", o_mispredict_cnt); else passed++;
    i_f_pc = 32'hFFFF_FFFC; i_ex_pc = 32'hFFFF_FFFC; i_imm = 32'h8;
    #1;
    total++; if (o_f_pred_pc !== 32'h0) $display("FAIL wrap_pred_pc got=%0h exp=0", o_f_pred_pc); else passed++;
    total++; if (o_pc_4 !== 32'h0) $display("FAIL wrap_pc_4 got=%0h exp=0", o_pc_4); else passed++;
    total++; if (o_pc_imm !== 32'h4) $display("FAIL wrap_pc_imm got=%0h exp=4", o_pc_imm); else passed++;
  endtask

  task automatic test_reset_priority();
    step();
    rst = 1; i_ex_valid = 1; i_ex_pc = 32'h100; i_jal = 1; i_imm = 32'h40; i_f_pc = 32'h100;
    @(negedge clk);
    total++; if (o_redirect !== 1'b1) $display("FAIL rst_redirect_follows got=%0h exp=1", o_redirect); else passed++;
    step(); rst = 0; clear_ex();
    @(negedge clk);
    total++; if (o_f_pred_taken !== 1'b0) $display("FAIL rst_drop_write got=%0h exp=0", o_f_pred_taken); else passed++;
    total++; if (o_mispredict_cnt !== 16'd0) $display("FAIL rst_cnt got=%0d exp=0", o_mispredict_cnt); else passed++;
    i_f_pc = 32'h300;
    #1;
    total++; if (o_f_pred_pc !== 32'h304) $display("FAIL rst_clears_btb got=%0h exp=304", o_f_pred_pc); else passed++;
  endtask

  initial begin
    test_reset();
    test_jal();
    test_alias_invalidate();
    test_branch();
    test_jalr();
    test_intr_mret();
    test_ex_invalid_wrap();
    test_reset_priority();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
